uart_frame_tx: RTL and testbench
================================

# uart_frame_tx

Parametrised frame serializer between the application and the byte-level UART transmitter. On a `send` request it snapshots a `NUM_BYTES`-wide payload vector. It then issues the bytes one at a time to the UART transmitter with a send/done handshake, optionally framed by a fixed header byte and a trailing XOR checksum byte. When the last byte completes it signals `send_done`. It generalises the fixed 40-byte, LSB-first sender with configurable length, byte order, framing and input snapshotting.

## Interface
- `NUM_BYTES`, default 40: payload length in bytes, minimum 1.
- `MSB_FIRST`, default 0: 0 sends `data[7:0]` first; 1 sends the top byte first.
- `USE_HEADER`, default 1: prepend `HEADER` byte.
- `HEADER`, default 8'hA5: header value.
- `USE_CHECKSUM`, default 1: append XOR of all payload bytes (header excluded).
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `send`  in  1  frame request; sampled only in IDLE.
- `data`  in  NUM_BYTES*8  payload; captured on the accepting cycle.
- `busy`  out  1  high from acceptance until send_done cycle inclusive.
- `send_done`  out  1  one-cycle pulse after the final byte completes.
- `uart_send`  out  1  one-cycle strobe to the UART transmitter.
- `send_data`  out  8  byte to transmit; valid with `uart_send`, held until the matching done.
- `uart_send_done`  in  1  UART transmitter byte-complete pulse.

## Operation
- Total bytes N_TOT = NUM_BYTES + USE_HEADER + USE_CHECKSUM. Index counter width is $clog2(N_TOT+1).
- States:
  - IDLE:
    - `send`=1 → latch `data` into the shadow register, clear index and checksum, go ISSUE.
  - ISSUE:
    - Drive `send_data` with byte[index] and assert `uart_send` for exactly one cycle.
    - If the byte is a payload byte, XOR it into the checksum.
    - Go WAIT.
  - WAIT:
    - Hold `send_data`.
    - On `uart_send_done`: index+1; if index was N_TOT-1, go DONE; else go ISSUE.
  - DONE:
    - `send_done`=1 for one cycle, go IDLE.
- Byte order with all options on: HEADER, payload bytes, checksum.
  - Payload byte k (k=0..NUM_BYTES-1) is `data[8k+7:8k]`, or `data[8(NUM_BYTES-1-k)+7 : 8(NUM_BYTES-1-k)]` when MSB_FIRST=1.
- The checksum is an 8-bit XOR of the payload bytes in transmission order and is sent as the final byte.
- The `data` input is not observed after acceptance; changes mid-frame have no effect.
- `send` outside IDLE is ignored. It is not queued.
- `uart_send_done` outside WAIT is ignored, including when it coincides with the ISSUE cycle.

## Timing
- Reset (rst=0 at an edge): state IDLE; `busy`, `send_done`, `uart_send` = 0; `send_data` = 8'h00; index and checksum = 0.
  - Reset mid-frame aborts immediately with no `send_done`. A byte already handed to the UART is not recalled.
- All outputs are registered.
- `send` high in IDLE at edge t:
  - `busy`=1 from t+1.
  - First `uart_send` at t+1.
- `uart_send_done` seen in WAIT at edge t:
  - If more bytes remain, the next `uart_send` occurs at t+1.
  - After the final byte, `send_done` occurs at t+1 and IDLE is reached at t+2.
  - A new `send` is accepted at t+2 at the earliest.
- Minimum per-byte period is 2 cycles (ISSUE + WAIT with immediate done).
- Minimum frame is 2·N_TOT + 2 cycles from acceptance to IDLE.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t` (IDLE, ISSUE, WAIT, DONE);
  - constant `UART_DEFAULT_HEADER` = 8'hA5.
- One sub-module, `uart_byte_sel`:
  - combinational selection of byte[index] from the shadow register, honouring MSB_FIRST, USE_HEADER and USE_CHECKSUM;
  - keeps the FSM file free of width arithmetic.
- Everything else (FSM, shadow register, index, checksum) lives in `uart_frame_tx`.

## Test plan
- NUM_BYTES=4, defaults, data=32'h44332211, UART model done 3 cycles after each strobe:
  - required bytes A5, 11, 22, 33, 44, 44 (checksum);
  - one `send_done` pulse; `busy` low afterwards.
- Same data, MSB_FIRST=1: required bytes A5, 44, 33, 22, 11, 44.
- USE_HEADER=0, USE_CHECKSUM=0, NUM_BYTES=1, data=8'h5A, done on the cycle right after the strobe:
  - `uart_send` at t+1, `send_done` at t+3, IDLE at t+4.
- Data changes to 32'hFFFFFFFF after acceptance: transmitted bytes still A5, 11, 22, 33, 44, 44.
- `send` held high continuously:
  - back-to-back frames, with the next acceptance exactly one cycle after `send_done`;
  - stray `uart_send_done` pulses in IDLE and during ISSUE cause no extra bytes.
- rst=0 asserted during the third byte's WAIT:
  - all outputs return to reset values at the next edge; no `send_done`;
  - a subsequent `send` restarts the frame at the header byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame transmitter.
// FSM state encoding and default framing header byte.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } uart_tx_state_t;

  localparam logic [7:0] UART_DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_frame_tx_byte_sel.sv
// Picks the byte at a frame index: header, payload (either order) or checksum.
// Purely combinational; flags payload bytes so the caller can fold them into the XOR.
module uart_byte_sel
  import uart_pkg::*;
#(
  parameter int         NUM_BYTES    = 40,
  parameter int         MSB_FIRST    = 0,
  parameter int         USE_HEADER   = 1,
  parameter int         USE_CHECKSUM = 1,
  parameter logic [7:0] HEADER       = UART_DEFAULT_HEADER,
  parameter int         N_TOT        = NUM_BYTES + USE_HEADER + USE_CHECKSUM,
  parameter int         IW           = $clog2(N_TOT + 1)
) (
  input  logic [NUM_BYTES*8-1:0] i_shadow,
  input  logic [IW-1:0]          i_idx,
  input  logic [7:0]             i_csum,
  output logic [7:0]             o_byte,
  output logic                   o_is_pay
);

  always_comb begin
    o_byte   = 8'h00;
    o_is_pay = 1'b0;
    if (USE_HEADER != 0 && i_idx == '0) begin
      o_byte = HEADER;
    end else if (USE_CHECKSUM != 0 && i_idx == IW'(N_TOT - 1)) begin
      o_byte = i_csum;
    end else begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (i_idx == IW'(k + USE_HEADER)) begin
          o_byte   = i_shadow[8*((MSB_FIRST != 0) ? (NUM_BYTES-1-k) : k) +: 8];
          o_is_pay = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Frame serializer: snapshots a payload and feeds it byte-by-byte to a UART
// transmitter with send/done handshake, optional header and XOR checksum.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int         NUM_BYTES    = 40,
  parameter int         MSB_FIRST    = 0,
  parameter int         USE_HEADER   = 1,
  parameter logic [7:0] HEADER       = UART_DEFAULT_HEADER,
  parameter int         USE_CHECKSUM = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   send,
  input  logic [NUM_BYTES*8-1:0] data,
  output logic                   busy,
  output logic                   send_done,
  output logic                   uart_send,
  output logic [7:0]             send_data,
  input  logic                   uart_send_done
);

  localparam int N_TOT = NUM_BYTES + USE_HEADER + USE_CHECKSUM;
  localparam int IW    = $clog2(N_TOT + 1);
  localparam logic [IW-1:0] LAST = IW'(N_TOT - 1);

  uart_tx_state_t         r_state;
  logic [NUM_BYTES*8-1:0] r_shadow;
  logic [IW-1:0]          r_idx;
  logic [7:0]             r_csum;
  logic                   r_busy;
  logic                   r_send_done;
  logic                   r_uart_send;
  logic [7:0]             r_send_data;

  logic                   w_idle;
  logic [NUM_BYTES*8-1:0] w_src;
  logic [IW-1:0]          w_idx_sel;
  logic [7:0]             w_csum_sel;
  logic [7:0]             w_csum_nxt;
  logic [7:0]             w_byte;
  logic                   w_is_pay;

  // Outputs are registered, so the next byte is selected from the
  // values the shadow/index/checksum take at the issuing edge.
  always_comb begin
    w_idle     = (r_state == IDLE);
    w_src      = w_idle ? data : r_shadow;
    w_idx_sel  = w_idle ? '0 : r_idx + IW'(1);
    w_csum_sel = w_idle ? 8'h00 : r_csum;
    w_csum_nxt = w_is_pay ? (w_csum_sel ^ w_byte) : w_csum_sel;
  end

  uart_byte_sel #(
    .NUM_BYTES   (NUM_BYTES),
    .MSB_FIRST   (MSB_FIRST),
    .USE_HEADER  (USE_HEADER),
    .USE_CHECKSUM(USE_CHECKSUM),
    .HEADER      (HEADER)
  ) u_sel (
    .i_shadow(w_src),
    .i_idx   (w_idx_sel),
    .i_csum  (w_csum_sel),
    .o_byte  (w_byte),
    .o_is_pay(w_is_pay)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shadow    <= '0;
      r_idx       <= '0;
      r_csum      <= 8'h00;
      r_busy      <= 1'b0;
      r_send_done <= 1'b0;
      r_uart_send <= 1'b0;
      r_send_data <= 8'h00;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (send) begin
            r_shadow    <= data;
            r_idx       <= '0;
            r_csum      <= w_csum_nxt;
            r_busy      <= 1'b1;
            r_uart_send <= 1'b1;
            r_send_data <= w_byte;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_uart_send <= 1'b0;
          r_state     <= WAIT;
        end
        WAIT: begin
          if (uart_send_done) begin
            r_idx <= w_idx_sel;
            if (r_idx == LAST) begin
              r_send_done <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_csum      <= w_csum_nxt;
              r_uart_send <= 1'b1;
              r_send_data <= w_byte;
              r_state     <= ISSUE;
            end
          end
        end
        DONE: begin
          r_send_done <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign send_done = r_send_done;
  assign uart_send = r_uart_send;
  assign send_data = r_send_data;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: three configurations, byte capture,
// timing, back-to-back, stray-done and mid-frame reset sequences.
module tb_uart_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        send_a = 1'b0, send_b = 1'b0, send_c = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic [7:0]  data_c = '0;
  logic        busy_a, busy_b, busy_c;
  logic        sd_a, sd_b, sd_c;
  logic        us_a, us_b, us_c;
  logic [7:0]  sdat_a, sdat_b, sdat_c;
  logic        ud_a, ud_b, ud_c;
  logic [2:0]  resp = '0;
  logic        stray_en = 1'b0;
  logic        idle_pulse = 1'b0;
  logic [2:0]  us_v, sd_v;

  assign ud_a = resp[0] | (stray_en & us_a) | idle_pulse;
  assign ud_b = resp[1];
  assign ud_c = resp[2];
  assign us_v = {us_c, us_b, us_a};
  assign sd_v = {sd_c, sd_b, sd_a};

  uart_frame_tx #(.NUM_BYTES(4)) u_a (
    .clk(clk), .rst(rst), .send(send_a), .data(data_a),
    .busy(busy_a), .send_done(sd_a), .uart_send(us_a),
    .send_data(sdat_a), .uart_send_done(ud_a));

  uart_frame_tx #(.NUM_BYTES(4), .MSB_FIRST(1)) u_b (
    .clk(clk), .rst(rst), .send(send_b), .data(data_b),
    .busy(busy_b), .send_done(sd_b), .uart_send(us_b),
    .send_data(sdat_b), .uart_send_done(ud_b));

  uart_frame_tx #(.NUM_BYTES(1), .USE_HEADER(0), .USE_CHECKSUM(0)) u_c (
    .clk(clk), .rst(rst), .send(send_c), .data(data_c),
    .busy(busy_c), .send_done(sd_c), .uart_send(us_c),
    .send_data(sdat_c), .uart_send_done(ud_c));

  int dly [3] = '{3, 3, 1};
  int cnt [3] = '{0, 0, 0};
  int sdc [3] = '{0, 0, 0};
  int cyc = 0;
  logic [7:0] qa[$], qb[$], qc[$];
  int tus_a[$], tsd_a[$];
  int nvec = 0, nerr = 0;

  // UART model: done pulse dly cycles after each strobe, plus capture.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      resp[i] = 1'b0;
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) resp[i] = 1'b1;
      end
      if (us_v[i]) cnt[i] = dly[i];
      if (sd_v[i]) sdc[i]++;
    end
    if (us_a) begin qa.push_back(sdat_a); tus_a.push_back(cyc); end
    if (us_b) qb.push_back(sdat_b);
    if (us_c) qc.push_back(sdat_c);
    if (sd_a) tsd_a.push_back(cyc);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic logic [7:0] qget(input int d, input int i);
    if (i >= qsize(d)) return 8'hxx;
    case (d)
      0:       return qa[i];
      1:       return qb[i];
      default: return qc[i];
    endcase
  endfunction

  function automatic logic getbusy(input int d);
    case (d)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic frame(input int d, input logic [31:0] dat, input bit mut,
                       input int n, input logic [47:0] exp, input string nm);
    int  s0;
    bit  to;
    qa.delete(); qb.delete(); qc.delete();
    s0 = sdc[d];
    step();
    case (d)
      0:       begin data_a = dat; send_a = 1'b1; end
      1:       begin data_b = dat; send_b = 1'b1; end
      default: begin data_c = dat[7:0]; send_c = 1'b1; end
    endcase
    step();
    send_a = 1'b0; send_b = 1'b0; send_c = 1'b0;
    if (mut) begin data_a = '1; data_b = '1; data_c = '1; end
    to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (sdc[d] != s0) begin to = 1'b0; break; end
      step();
    end
    chk({nm, "_timeout"}, 32'(to), 32'd0);
    step();
    chk({nm, "_busy_after"}, 32'(getbusy(d)), 32'd0);
    chk({nm, "_done_pulses"}, 32'(sdc[d] - s0), 32'd1);
    chk({nm, "_nbytes"}, 32'(qsize(d)), 32'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", nm, i), 32'(qget(d, i)),
          32'(exp[47-8*i -: 8]));
  endtask

  typedef struct {
    int          d;
    logic [31:0] dat;
    bit          mut;
    int          n;
    logic [47:0] exp;
  } vec_t;

  vec_t tv [6];

  initial begin
    int  s0;
    bit  to;
    logic [47:0] fr;

    tv[0] = '{0, 32'h44332211, 1'b0, 6, 48'hA5_11_22_33_44_44};
    tv[1] = '{1, 32'h44332211, 1'b0, 6, 48'hA5_44_33_22_11_44};
    tv[2] = '{0, 32'h01020304, 1'b0, 6, 48'hA5_04_03_02_01_04};
    tv[3] = '{0, 32'h44332211, 1'b1, 6, 48'hA5_11_22_33_44_44};
    tv[4] = '{1, 32'hDEADBEEF, 1'b0, 6, 48'hA5_DE_AD_BE_EF_22};
    tv[5] = '{2, 32'h0000005A, 1'b0, 1, 48'h5A_00_00_00_00_00};

    rst = 1'b0;
    repeat (3) step();
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_us_a", 32'(us_a), 0);
    chk("rst_sd_a", 32'(sd_a), 0);
    chk("rst_sdat_a", 32'(sdat_a), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    chk("rst_sdat_c", 32'(sdat_c), 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      frame(tv[i].d, tv[i].dat, tv[i].mut, tv[i].n, tv[i].exp,
            $sformatf("v%0d", i));

    // Minimum-latency single byte: strobe t+1, done t+3, idle t+4.
    qc.delete();
    step();
    data_c = 8'h5A; send_c = 1'b1;
    step();
    send_c = 1'b0;
    chk("c_t1_us", 32'(us_c), 1);
    chk("c_t1_busy", 32'(busy_c), 1);
    chk("c_t1_data", 32'(sdat_c), 32'h5A);
    step();
    chk("c_t2_us", 32'(us_c), 0);
    chk("c_t2_sd", 32'(sd_c), 0);
    step();
    chk("c_t3_sd", 32'(sd_c), 1);
    chk("c_t3_busy", 32'(busy_c), 1);
    step();
    chk("c_t4_sd", 32'(sd_c), 0);
    chk("c_t4_busy", 32'(busy_c), 0);

    // Stray done in IDLE and on every ISSUE cycle; send held high.
    step();
    idle_pulse = 1'b1;
    step();
    idle_pulse = 1'b0;
    step();
    chk("stray_idle_bytes", 32'(qa.size()), 0);
    chk("stray_idle_busy", 32'(busy_a), 0);
    stray_en = 1'b1;
    qa.delete(); tus_a.delete(); tsd_a.delete();
    s0 = sdc[0];
    data_a = 32'h44332211;
    send_a = 1'b1;
    to = 1'b1;
    for (int k = 0; k < 800; k++) begin
      if (sdc[0] - s0 >= 2) begin to = 1'b0; break; end
      step();
    end
    send_a = 1'b0;
    step();
    step();
    stray_en = 1'b0;
    chk("b2b_timeout", 32'(to), 0);
    chk("b2b_nbytes", 32'(qa.size()), 12);
    fr = 48'hA5_11_22_33_44_44;
    for (int i = 0; i < 12; i++)
      chk($sformatf("b2b_byte%0d", i), 32'(qget(0, i)),
          32'(fr[47-8*(i%6) -: 8]));
    if (tus_a.size() >= 7 && tsd_a.size() >= 1)
      chk("b2b_gap", 32'(tus_a[6] - tsd_a[0]), 2);
    else
      chk("b2b_gap_missing", 32'(tus_a.size()), 7);

    // Reset during third byte's WAIT.
    qa.delete();
    s0 = sdc[0];
    step();
    data_a = 32'h44332211; send_a = 1'b1;
    step();
    send_a = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (qa.size() >= 3) begin to = 1'b0; break; end
      step();
    end
    chk("rstm_timeout", 32'(to), 0);
    step();
    rst = 1'b0;
    step();
    chk("rstm_busy", 32'(busy_a), 0);
    chk("rstm_us", 32'(us_a), 0);
    chk("rstm_sd", 32'(sd_a), 0);
    chk("rstm_sdat", 32'(sdat_a), 0);
    rst = 1'b1;
    repeat (6) step();
    chk("rstm_no_done", 32'(sdc[0] - s0), 0);
    chk("rstm_nbytes", 32'(qa.size()), 3);
    frame(0, 32'h44332211, 1'b0, 6, 48'hA5_11_22_33_44_44, "rst_recover");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
